// File: rtl/lpc_buff_sched.sv
// Round-robin scheduler handing four 2048-byte sound buffers to the LPC transmitter.
// Tracks per-buffer full flags, issues one buffer at a time and flags writer overrun / transmitter stall.
module lpc_buff_sched #(
    parameter int unsigned     TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'd2_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] wr_done,
    input  logic       packet_SENT,
    input  logic       clr_err,
    output logic [3:0] buff_RDY,
    output logic [1:0] buf_sel,
    output logic [3:0] buff_full,
    output logic       active,
    output logic       overrun,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMER_TC = TIMEOUT - 1'b1;

    state_t          state_q, state_d;
    logic [1:0]      buf_sel_q, buf_sel_d;
    logic [1:0]      last_sel_q, last_sel_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [3:0]      full_q, full_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      overrun_cnt_q, overrun_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            in_xmit;
    logic            timer_tc;
    logic            issue;
    logic            rel;
    logic            timeout_evt;
    logic [3:0]      rel_mask;
    logic            ov_evt;

    // Search begins one past the last released buffer so every full buffer gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = last_sel_q + 2'(k + 1);
            if (!win_found && full_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        in_xmit     = (state_q == S_XMIT);
        timer_tc    = (timer_q == TIMER_TC);
        issue       = (state_q == S_IDLE) && enable && win_found;
        rel         = in_xmit && (packet_SENT || timer_tc);
        // A packet that completes on the last allowed cycle is a normal release, not a stall.
        timeout_evt = in_xmit && !packet_SENT && timer_tc;
        rel_mask    = rel ? (4'b0001 << buf_sel_q) : 4'b0000;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_XMIT;
            S_XMIT:  if (rel)   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active   = (state_q == S_XMIT);
        buff_RDY = active ? (4'b0001 << buf_sel_q) : 4'b0000;
    end

    always_comb begin
        buf_sel_d  = issue ? win_idx : buf_sel_q;
        last_sel_d = rel ? buf_sel_q : last_sel_q;

        timer_d = timer_q;
        if (issue) begin
            timer_d = '0;
        end else if (in_xmit && !rel) begin
            timer_d = timer_q + 1'b1;
        end

        // A refill landing on the release cycle leaves the flag set without counting as overrun.
        full_d = (full_q & ~rel_mask) | wr_done;
        ov_evt = |(wr_done & full_q & ~rel_mask);

        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;
        if (ov_evt) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = (overrun_cnt_q == 8'hFF) ? overrun_cnt_q : overrun_cnt_q + 8'd1;
        end else if (clr_err) begin
            overrun_d     = 1'b0;
            overrun_cnt_d = 8'd0;
        end

        timeout_err_d = timeout_err_q;
        if (timeout_evt) begin
            timeout_err_d = 1'b1;
        end else if (clr_err) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_sel_q     <= 2'd0;
            last_sel_q    <= 2'd3;
            timer_q       <= '0;
            full_q        <= 4'b0000;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            buf_sel_q     <= buf_sel_d;
            last_sel_q    <= last_sel_d;
            timer_q       <= timer_d;
            full_q        <= full_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign buf_sel     = buf_sel_q;
    assign buff_full   = full_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lpc_buff_sched.sv
// Directed bench for lpc_buff_sched: issue order, latency, overrun, timeout and async reset.
module tb_lpc_buff_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] wr_done;
    logic       packet_SENT;
    logic       clr_err;
    logic [3:0] buff_RDY;
    logic [1:0] buf_sel;
    logic [3:0] buff_full;
    logic       active;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic       timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    lpc_buff_sched #(.TO_W(24), .TIMEOUT(24'd100)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .wr_done     (wr_done),
        .packet_SENT (packet_SENT),
        .clr_err     (clr_err),
        .buff_RDY    (buff_RDY),
        .buf_sel     (buf_sel),
        .buff_full   (buff_full),
        .active      (active),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Release the current packet, then expect the GAP/IDLE bubble and the next issue.
    task automatic send_expect_next(input string tag, input logic [3:0] rdy, input logic [1:0] sel);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;
        chk({tag, "_rel"}, 32'(buff_RDY), 32'h0);
        tick();
        chk({tag, "_gap"}, 32'(buff_RDY), 32'h0);
        tick();
        chk({tag, "_rdy"}, 32'(buff_RDY), 32'(rdy));
        chk({tag, "_sel"}, 32'(buf_sel), 32'(sel));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wr_done = 4'b0; packet_SENT = 1'b0; clr_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_rdy", 32'(buff_RDY), 32'h0);
        chk("rst_sel", 32'(buf_sel), 32'h0);
        chk("rst_full", 32'(buff_full), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_cnt", 32'(overrun_cnt), 32'h0);
        chk("rst_to", 32'(timeout_err), 32'h0);

        // 1: latency wr_done -> full -> buff_RDY
        enable = 1'b1;
        wr_done = 4'b0001;
        tick();
        wr_done = 4'b0000;
        chk("t1_full", 32'(buff_full), 32'h1);
        chk("t1_rdy_early", 32'(buff_RDY), 32'h0);
        tick();
        chk("t1_rdy", 32'(buff_RDY), 32'h1);
        chk("t1_sel", 32'(buf_sel), 32'h0);
        chk("t1_active", 32'(active), 32'h1);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;
        chk("t1_rel_rdy", 32'(buff_RDY), 32'h0);
        chk("t1_rel_full", 32'(buff_full), 32'h0);
        chk("t1_rel_active", 32'(active), 32'h0);

        // 2: round robin from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_done = 4'b1111;
        tick();
        wr_done = 4'b0000;
        tick();
        chk("t2_rdy0", 32'(buff_RDY), 32'h1);
        send_expect_next("t2_b1", 4'b0010, 2'd1);
        chk("t2_full_after0", 32'(buff_full), 32'hE);
        send_expect_next("t2_b2", 4'b0100, 2'd2);
        send_expect_next("t2_b3", 4'b1000, 2'd3);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;
        chk("t2_empty", 32'(buff_full), 32'h0);
        wr_done = 4'b0101;
        tick();
        wr_done = 4'b0000;
        tick();
        chk("t2_wrap_rdy", 32'(buff_RDY), 32'h1);
        send_expect_next("t2_b2b", 4'b0100, 2'd2);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;

        // 3: overrun while buffer 1 transmits, refill on release, clear
        wr_done = 4'b0010;
        tick();
        wr_done = 4'b0000;
        tick();
        chk("t3_rdy", 32'(buff_RDY), 32'h2);
        wr_done = 4'b0010;
        tick();
        wr_done = 4'b0000;
        chk("t3_ovr", 32'(overrun), 32'h1);
        chk("t3_cnt", 32'(overrun_cnt), 32'h1);
        wr_done = 4'b0010;
        packet_SENT = 1'b1;
        tick();
        wr_done = 4'b0000;
        packet_SENT = 1'b0;
        chk("t3_refill_full", 32'(buff_full), 32'h2);
        chk("t3_refill_cnt", 32'(overrun_cnt), 32'h1);
        chk("t3_refill_rdy", 32'(buff_RDY), 32'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr_ovr", 32'(overrun), 32'h0);
        chk("t3_clr_cnt", 32'(overrun_cnt), 32'h0);
        tick();
        chk("t3_reissue", 32'(buff_RDY), 32'h2);

        // 4: timeout on buffer 1, buffer 3 waiting
        wr_done = 4'b1000;
        tick();
        wr_done = 4'b0000;
        for (int i = 0; i < 98; i++) tick();
        chk("t4_pre_rdy", 32'(buff_RDY), 32'h2);
        chk("t4_pre_to", 32'(timeout_err), 32'h0);
        tick();
        chk("t4_to", 32'(timeout_err), 32'h1);
        chk("t4_rel_rdy", 32'(buff_RDY), 32'h0);
        chk("t4_rel_full", 32'(buff_full), 32'h8);
        tick();
        chk("t4_gap", 32'(buff_RDY), 32'h0);
        tick();
        chk("t4_next_rdy", 32'(buff_RDY), 32'h8);
        chk("t4_next_sel", 32'(buf_sel), 32'h3);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;
        chk("t4_done_full", 32'(buff_full), 32'h0);

        // 5: overrun saturation with issue disabled, stray packet_SENT ignored
        enable = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_to_clr", 32'(timeout_err), 32'h0);
        wr_done = 4'b0001;
        tick();
        for (int i = 0; i < 300; i++) tick();
        wr_done = 4'b0000;
        chk("t5_sat", 32'(overrun_cnt), 32'hFF);
        chk("t5_ovr", 32'(overrun), 32'h1);
        packet_SENT = 1'b1;
        tick();
        packet_SENT = 1'b0;
        chk("t5_stray_full", 32'(buff_full), 32'h1);
        chk("t5_noissue", 32'(buff_RDY), 32'h0);

        // 6: async reset mid-packet, then search restarts at buffer 0
        enable = 1'b1;
        tick();
        chk("t6_rdy", 32'(buff_RDY), 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_async_rdy", 32'(buff_RDY), 32'h0);
        chk("t6_full", 32'(buff_full), 32'h0);
        chk("t6_cnt", 32'(overrun_cnt), 32'h0);
        chk("t6_active", 32'(active), 32'h0);
        tick();
        reset = 1'b0;
        enable = 1'b0;
        wr_done = 4'b0100;
        tick();
        wr_done = 4'b0000;
        enable = 1'b1;
        tick();
        chk("t6_rdy2", 32'(buff_RDY), 32'h4);
        chk("t6_sel2", 32'(buf_sel), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
